// File: rtl/pitch_tracker.sv
// pitch_tracker: rising zero-crossing counter with hysteresis over a fixed sample window, scaled to Hz, gated by a peak-amplitude voicing decision.
// Latency: window results appear 1 clk after the closing valid sample; freq_valid_o pulses for one cycle.
// Backpressure: none; accepts a sample on any cycle with sample_valid_in. Optional PITCH_SMOOTH_EN applies a 3:1 IIR to voiced results.
module pitch_tracker #(
   parameter int SAMPLE_W       = 16,
   parameter int HYST           = 256,
   parameter int WINDOW_SAMPLES = 1500,
   parameter int SCALE_SHIFT    = 4,
   parameter int SILENCE_THRESH = 1024,
   parameter int COUNT_W        = 12
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid_in,
   output logic [15:0]         freq_out,
   output logic                freq_valid_out,
   output logic                voiced_out
);

   localparam int WIN_W  = (WINDOW_SAMPLES > 1) ? $clog2(WINDOW_SAMPLES) : 1;
   localparam int WIDE_W = COUNT_W + SCALE_SHIFT + 17;

   localparam logic signed [SAMPLE_W:0] HYST_POS = (SAMPLE_W+1)'(HYST);
   localparam logic signed [SAMPLE_W:0] HYST_NEG = -((SAMPLE_W+1)'(HYST));
   localparam logic [WIN_W-1:0]         WIN_LAST = WIN_W'(WINDOW_SAMPLES - 1);
   localparam logic [SAMPLE_W-1:0]      THRESH   = SAMPLE_W'(SILENCE_THRESH);
   localparam logic [SAMPLE_W-1:0]      MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
   localparam logic [SAMPLE_W-1:0]      MOST_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};

   typedef enum logic {
      ARM_LOW  = 1'b0,
      ARM_HIGH = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
   logic [COUNT_W-1:0]   cnt_q, cnt_d;
   logic [SAMPLE_W-1:0]  peak_q, peak_d;
   logic [15:0]          freq_q, freq_d;
   logic                 valid_q, valid_d;
   logic                 voiced_q, voiced_d;

   // Sign-extended sample for the signed hysteresis comparisons.
   logic signed [SAMPLE_W:0] samp_s;
   logic                     cross_hit;
   logic [SAMPLE_W-1:0]      abs_samp;
   logic [SAMPLE_W-1:0]      peak_upd;
   logic [COUNT_W-1:0]       cnt_upd;
   logic                     win_last;
   logic                     voiced_new;
   logic [WIDE_W-1:0]        scaled;
   logic [15:0]              freq_sat;
   logic [15:0]              freq_new;

   assign samp_s = $signed({sample_in[SAMPLE_W-1], sample_in});

   // Crossing FSM state register; it carries across window boundaries.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= ARM_LOW;
      end else begin
         state_q <= state_d;
      end
   end

   // Crossing FSM next state: arm below -HYST, count a crossing at or above +HYST.
   always_comb begin
      state_d   = state_q;
      cross_hit = 1'b0;
      if (sample_valid_in) begin
         case (state_q)
            ARM_LOW: begin
               if (samp_s <= HYST_NEG) begin
                  state_d = ARM_HIGH;
               end
            end
            ARM_HIGH: begin
               if (samp_s >= HYST_POS) begin
                  state_d   = ARM_LOW;
                  cross_hit = 1'b1;
               end
            end
            default: state_d = ARM_LOW;
         endcase
      end
   end

   // Magnitude of the current sample; the most negative code maps to full-scale positive.
   always_comb begin
      abs_samp = sample_in;
      if (sample_in == MOST_NEG) begin
         abs_samp = MOST_POS;
      end else if (sample_in[SAMPLE_W-1]) begin
         abs_samp = -sample_in;
      end
   end

   // Window accumulators including the current sample, so a closing sample counts in its own window.
   always_comb begin
      peak_upd   = (abs_samp > peak_q) ? abs_samp : peak_q;
      cnt_upd    = (cross_hit && (cnt_q != {COUNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;
      win_last   = (win_cnt_q == WIN_LAST);
      voiced_new = (peak_upd >= THRESH);
   end

   // Scale crossings to Hz at full width, then clamp to the 16-bit output range.
   always_comb begin
      scaled   = WIDE_W'(cnt_upd) << SCALE_SHIFT;
      freq_sat = (scaled > WIDE_W'(17'h0FFFF)) ? 16'hFFFF : scaled[15:0];
   end

`ifdef PITCH_SMOOTH_EN
   logic [17:0] smooth_sum;

   // Blend 3:1 with the previous estimate when the previous window was voiced, else load directly.
   always_comb begin
      smooth_sum = (18'(freq_q) * 18'd3) + 18'(freq_sat);
      freq_new   = voiced_q ? 16'(smooth_sum >> 2) : freq_sat;
   end
`else
   // Unsmoothed build: each voiced window publishes its own estimate.
   always_comb begin
      freq_new = freq_sat;
   end
`endif

   // Window bookkeeping and result publication on the closing sample.
   always_comb begin
      win_cnt_d = win_cnt_q;
      cnt_d     = cnt_q;
      peak_d    = peak_q;
      freq_d    = freq_q;
      voiced_d  = voiced_q;
      valid_d   = 1'b0;
      if (sample_valid_in) begin
         if (win_last) begin
            win_cnt_d = '0;
            cnt_d     = '0;
            peak_d    = '0;
            valid_d   = 1'b1;
            voiced_d  = voiced_new;
            if (voiced_new) begin
               freq_d = freq_new;
            end
         end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            cnt_d     = cnt_upd;
            peak_d    = peak_upd;
         end
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         win_cnt_q <= '0;
         cnt_q     <= '0;
         peak_q    <= '0;
         freq_q    <= '0;
         valid_q   <= 1'b0;
         voiced_q  <= 1'b0;
      end else begin
         win_cnt_q <= win_cnt_d;
         cnt_q     <= cnt_d;
         peak_q    <= peak_d;
         freq_q    <= freq_d;
         valid_q   <= valid_d;
         voiced_q  <= voiced_d;
      end
   end

   assign freq_out       = freq_q;
   assign freq_valid_out = valid_q;
   assign voiced_out     = voiced_q;

endmodule

// File: tb/tb_pitch_tracker.sv
// Directed bench for pitch_tracker: default instance plus a SCALE_SHIFT=8 instance for saturation.
module tb_pitch_tracker;
   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic [15:0] sample_in = 16'd0;
   logic        sample_valid_in = 1'b0;
   logic        valid2 = 1'b0;
   logic [15:0] freq_out, freq2;
   logic        freq_valid_out, fvalid2;
   logic        voiced_out, voiced2;

   int checks = 0;
   int errors = 0;
   int pulse_cnt = 0;
   int pulse_cnt2 = 0;
   logic [15:0] exp_freq;

   pitch_tracker dut (
      .clk_in(clk_in), .rst_in(rst_in), .sample_in(sample_in),
      .sample_valid_in(sample_valid_in), .freq_out(freq_out),
      .freq_valid_out(freq_valid_out), .voiced_out(voiced_out)
   );

   pitch_tracker #(.SCALE_SHIFT(8)) dut_sat (
      .clk_in(clk_in), .rst_in(rst_in), .sample_in(sample_in),
      .sample_valid_in(valid2), .freq_out(freq2),
      .freq_valid_out(fvalid2), .voiced_out(voiced2)
   );

   always #5 clk_in = ~clk_in;

   always @(negedge clk_in) begin
      if (freq_valid_out) pulse_cnt <= pulse_cnt + 1;
      if (fvalid2) pulse_cnt2 <= pulse_cnt2 + 1;
   end

   // Stimulus patterns indexed by sample position within a window.
   function automatic logic [15:0] gen(input int mode, input int i);
      logic signed [15:0] v;
      v = 16'sd0;
      case (mode)
         0: v = (i % 30 < 15) ? -16'sd8000 : 16'sd8000;
         1: v = (i % 30 < 15) ? -16'sd200 : 16'sd200;
         2: begin
            if (i == 0) v = 16'sd2000;
            else if (i <= 400) v = (i % 2 == 1) ? 16'sd300 : -16'sd100;
            else if (i == 1498) v = -16'sd300;
            else if (i == 1499) v = 16'sd300;
            else v = 16'sd0;
         end
         3: v = (i == 1499) ? 16'sh8000 : 16'sd0;
         4: v = (i % 2 == 0) ? -16'sd20000 : 16'sd20000;
         5: v = (i % 15 < 7) ? -16'sd8000 : 16'sd8000;
         default: v = 16'sd0;
      endcase
      return v;
   endfunction

   task automatic drive(input logic [15:0] s, input bit to2);
      sample_in = s;
      if (to2) valid2 = 1'b1;
      else sample_valid_in = 1'b1;
      @(negedge clk_in);
      sample_valid_in = 1'b0;
      valid2 = 1'b0;
   endtask

   task automatic feed(input int mode, input int first, input int last, input int gap, input bit to2);
      for (int i = first; i <= last; i++) begin
         drive(gen(mode, i), to2);
         repeat (gap) @(negedge clk_in);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++; if (freq_out !== 16'd0) begin errors++; $display("FAIL reset_freq got %0d want 0", freq_out); end
      checks++; if (freq_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", freq_valid_out); end
      checks++; if (voiced_out !== 1'b0) begin errors++; $display("FAIL reset_voiced got %b want 0", voiced_out); end
      @(negedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic test_square();
      int p0;
      for (int w = 0; w < 2; w++) begin
         p0 = pulse_cnt;
         feed(0, 0, 1498, 3, 1'b0);
         checks++; if (freq_valid_out !== 1'b0 || pulse_cnt != p0) begin errors++; $display("FAIL square_early_pulse w%0d valid %b pulses %0d want 0", w, freq_valid_out, pulse_cnt - p0); end
         feed(0, 1499, 1499, 0, 1'b0);
         checks++; if (freq_valid_out !== 1'b1) begin errors++; $display("FAIL square_pulse w%0d got %b want 1", w, freq_valid_out); end
         checks++; if (freq_out !== 16'd800) begin errors++; $display("FAIL square_freq w%0d got %0d want 800", w, freq_out); end
         checks++; if (voiced_out !== 1'b1) begin errors++; $display("FAIL square_voiced w%0d got %b want 1", w, voiced_out); end
         @(negedge clk_in);
         checks++; if (freq_valid_out !== 1'b0 || pulse_cnt != p0 + 1) begin errors++; $display("FAIL square_one_pulse w%0d valid %b pulses %0d want 1", w, freq_valid_out, pulse_cnt - p0); end
      end
      exp_freq = 16'd800;
   endtask

   task automatic test_reset_mid();
      int p0;
      feed(0, 0, 699, 0, 1'b0);
      #2 rst_in = 1'b1;
      #1;
      checks++; if (freq_out !== 16'd0 || freq_valid_out !== 1'b0 || voiced_out !== 1'b0) begin errors++; $display("FAIL midreset_async got freq %0d valid %b voiced %b want 0 0 0", freq_out, freq_valid_out, voiced_out); end
      @(negedge clk_in);
      rst_in = 1'b0;
      p0 = pulse_cnt;
      feed(0, 0, 1498, 0, 1'b0);
      checks++; if (pulse_cnt != p0 || freq_valid_out !== 1'b0 || freq_out !== 16'd0) begin errors++; $display("FAIL midreset_early pulses %0d freq %0d want 0 0", pulse_cnt - p0, freq_out); end
      feed(0, 1499, 1499, 0, 1'b0);
      checks++; if (freq_valid_out !== 1'b1 || freq_out !== 16'd800) begin errors++; $display("FAIL midreset_first valid %b freq %0d want 1 800", freq_valid_out, freq_out); end
      @(negedge clk_in);
      exp_freq = 16'd800;
   endtask

   task automatic test_unvoiced();
      int p0;
      for (int w = 0; w < 2; w++) begin
         p0 = pulse_cnt;
         feed(1, 0, 1499, 0, 1'b0);
         checks++; if (freq_valid_out !== 1'b1) begin errors++; $display("FAIL unvoiced_pulse w%0d got %b want 1", w, freq_valid_out); end
         checks++; if (voiced_out !== 1'b0 || freq_out !== exp_freq) begin errors++; $display("FAIL unvoiced_hold w%0d voiced %b freq %0d want 0 %0d", w, voiced_out, freq_out, exp_freq); end
         @(negedge clk_in);
         checks++; if (pulse_cnt != p0 + 1) begin errors++; $display("FAIL unvoiced_pulses w%0d got %0d want 1", w, pulse_cnt - p0); end
      end
   endtask

   task automatic test_hysteresis();
      feed(2, 0, 1499, 0, 1'b0);
      checks++; if (freq_valid_out !== 1'b1 || voiced_out !== 1'b1) begin errors++; $display("FAIL hyst_voiced valid %b voiced %b want 1 1", freq_valid_out, voiced_out); end
      checks++; if (freq_out !== 16'd16) begin errors++; $display("FAIL hyst_freq got %0d want 16", freq_out); end
      @(negedge clk_in);
      exp_freq = 16'd16;
   endtask

   task automatic test_negpeak();
`ifdef PITCH_SMOOTH_EN
      exp_freq = 16'd12;
`else
      exp_freq = 16'd0;
`endif
      feed(3, 0, 1499, 0, 1'b0);
      checks++; if (voiced_out !== 1'b1) begin errors++; $display("FAIL negpeak_voiced got %b want 1", voiced_out); end
      checks++; if (freq_out !== exp_freq) begin errors++; $display("FAIL negpeak_freq got %0d want %0d", freq_out, exp_freq); end
      @(negedge clk_in);
   endtask

   task automatic test_saturation();
      int p0, q0;
      p0 = pulse_cnt;
      q0 = pulse_cnt2;
      feed(4, 0, 1499, 0, 1'b1);
      checks++; if (fvalid2 !== 1'b1 || voiced2 !== 1'b1) begin errors++; $display("FAIL sat_pulse valid %b voiced %b want 1 1", fvalid2, voiced2); end
      checks++; if (freq2 !== 16'hFFFF) begin errors++; $display("FAIL sat_freq got %h want ffff", freq2); end
      @(negedge clk_in);
      checks++; if (pulse_cnt2 != q0 + 1 || pulse_cnt != p0) begin errors++; $display("FAIL sat_pulses got %0d/%0d want 1/0", pulse_cnt2 - q0, pulse_cnt - p0); end
   endtask

   task automatic test_gaps();
      feed(1, 0, 699, 0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         sample_in = (k % 2 == 0) ? 16'hB1E0 : 16'h4E20;
         @(negedge clk_in);
      end
      checks++; if (freq_out !== exp_freq || freq_valid_out !== 1'b0 || voiced_out !== 1'b1) begin errors++; $display("FAIL gap_idle freq %0d valid %b voiced %b want %0d 0 1", freq_out, freq_valid_out, voiced_out, exp_freq); end
      feed(1, 700, 1499, 0, 1'b0);
      checks++; if (freq_valid_out !== 1'b1 || voiced_out !== 1'b0 || freq_out !== exp_freq) begin errors++; $display("FAIL gap_window valid %b voiced %b freq %0d want 1 0 %0d", freq_valid_out, voiced_out, freq_out, exp_freq); end
      @(negedge clk_in);
   endtask

   task automatic test_smooth();
      feed(0, 0, 1499, 0, 1'b0);
      checks++; if (freq_out !== 16'd800 || voiced_out !== 1'b1) begin errors++; $display("FAIL smooth_first freq %0d voiced %b want 800 1", freq_out, voiced_out); end
      @(negedge clk_in);
`ifdef PITCH_SMOOTH_EN
      exp_freq = 16'd1000;
`else
      exp_freq = 16'd1600;
`endif
      feed(5, 0, 1499, 0, 1'b0);
      checks++; if (freq_out !== exp_freq || freq_valid_out !== 1'b1) begin errors++; $display("FAIL smooth_second freq %0d valid %b want %0d 1", freq_out, freq_valid_out, exp_freq); end
      @(negedge clk_in);
   endtask

   initial begin
      exp_freq = 16'd0;
      test_reset();
      test_square();
      test_reset_mid();
      test_unvoiced();
      test_hysteresis();
      test_negpeak();
      test_saturation();
      test_gaps();
      test_smooth();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
